// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one sync_fifo write port between NUM_REQ
//   producers. A grant lasts for at most MAX_BURST beats. The grant ends early
//   when the granted producer drops valid. FIFO full stalls the burst and never
//   ends it. Each new grant costs one IDLE cycle, which is used to arbitrate.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   req_valid   : [NUM_REQ]        producer i has a word available
//   req_data    : [NUM_REQ*WIDTH]  producer i word in [i*WIDTH +: WIDTH]
//   req_ready   : [NUM_REQ]        producer i word accepted this cycle
//   fifo_wen    : FIFO write enable
//   fifo_din    : [WIDTH] FIFO write data
//   fifo_wfull  : FIFO full flag
//   grant_id    : [ID_W] producer currently holding the grant
//   busy        : high while a grant is held
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wen,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_wfull,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  generate
    if (NUM_REQ < 2) begin : g_bad_num_req
      $error("fifo_wr_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic               found;
  logic [ID_W-1:0]    pick;
  logic               gnt_valid;
  logic               beat;
  logic               last_beat;

  // Circular priority search starting just after the last released producer,
  // so the producer that just finished has the lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (int'(last_id_q) + off) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Data mux; also drives fifo_din in IDLE where the value is don't-care.
  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        fifo_din = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign gnt_valid = req_valid[grant_id_q];
  assign beat      = (state_q == GRANT) && gnt_valid && !fifo_wfull;
  assign last_beat = beat && (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == GRANT) && (grant_id_q == ID_W'(i)) && !fifo_wfull;
    end
  end

  assign fifo_wen = beat;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        // A stall (valid high, FIFO full) matches neither condition and
        // therefore keeps the grant.
        if (last_beat || !gnt_valid) begin
          last_id_d = grant_id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
